uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte requesters sharing one UART transmitter, range 2..8.
REQ-002 Parameter BUSY_TIMEOUT, default 16: cycles allowed from trigger to transmitter busy assertion.
REQ-003 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n_in  input  1  asynchronous, active-low reset.
REQ-005 req_valid_in  input  NUM_REQ  per-requester byte valid.
REQ-006 req_data_in  input  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 req_last_in  input  NUM_REQ  marks the final byte of a requester's message.
REQ-008 req_ready_out  output  NUM_REQ  one-hot or zero; byte transfers when valid and ready are both high.
REQ-009 tx_data_out  output  8  byte presented to the transmitter.
REQ-010 tx_trigger_out  output  1  single-cycle start pulse to the transmitter.
REQ-011 tx_busy_in  input  1  transmitter busy flag, high one cycle after an accepted trigger until the stop bit completes.
REQ-012 grant_id_out  output  $clog2(NUM_REQ)  index of the requester owning the current byte.
REQ-013 grant_active_out  output  1  high from byte accept until return to IDLE.
REQ-014 timeout_err_out  output  1  single-cycle pulse on busy timeout.

Function
REQ-015 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-016 In IDLE with tx_busy_in low, req_ready_out SHALL be driven combinationally high for exactly the selected requester.
REQ-017 In any other state, or while tx_busy_in is high, req_ready_out SHALL be all zero.
REQ-018 Selection SHALL be round-robin, searching upward from (last_grant+1) mod NUM_REQ among requesters with valid high.
REQ-019 While the lock is set, only the locked requester SHALL be eligible; the arbiter waits indefinitely for its valid.
REQ-020 On transfer, the arbiter SHALL register the byte into tx_data_out, register the index into grant_id_out, set grant_active_out, and enter LAUNCH.
REQ-021 On transfer with last low, the arbiter SHALL set the lock to that requester.
REQ-022 On transfer with last high, the arbiter SHALL clear the lock and set last_grant to that requester.
REQ-023 The round-robin pointer SHALL NOT advance while the lock is set.
REQ-024 LAUNCH SHALL assert tx_trigger_out for exactly one cycle (accept cycle T, pulse at T+1), then enter WAIT_BUSY.
REQ-025 In WAIT_BUSY, when tx_busy_in is high the FSM SHALL enter WAIT_DONE.
REQ-026 In WAIT_BUSY, the cycle counter reaching BUSY_TIMEOUT SHALL pulse timeout_err_out, clear the lock, advance last_grant, and return to IDLE.
REQ-027 In WAIT_DONE, when tx_busy_in is low the FSM SHALL return to IDLE and clear grant_active_out; the next accept is possible in that IDLE cycle.
REQ-028 tx_data_out and grant_id_out SHALL hold stable from accept until the next accept.
REQ-029 A valid on a non-selected requester SHALL be ignored without side effect.
REQ-030 A valid on any requester SHALL NOT be acknowledged twice for one byte.

Reset
REQ-031 While rst_n_in is low, the block SHALL set state to IDLE, all outputs to 0, lock clear, counter 0, and last_grant NUM_REQ-1 so requester 0 has first priority.
REQ-032 Reset asserted mid-transfer SHALL drop tx_trigger_out and grant_active_out immediately and SHALL NOT re-trigger the lost byte.

Structure
REQ-033 Package uart_arb_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-034 The round-robin priority pick SHALL be a combinational sub-module named rr_pick (inputs: request vector, pointer; outputs: one-hot grant, index, any).

Verification
REQ-035 Requester 2 sends 0xA5 with last=1 against a busy model (busy 1 cycle after trigger, 10 cycles long) -> ready[2] for one cycle, trigger one cycle later, tx_data_out=0xA5, grant_id_out=2.
REQ-036 All four requesters hold valid with last=1 -> grant order 0,1,2,3,0 with one trigger per byte.
REQ-037 Requester 1 sends a 3-byte message (last on byte 3) while requesters 0 and 3 are valid -> grants 1,1,1,3,0.
REQ-038 tx_busy_in is held low after a trigger -> timeout_err_out pulses 16 cycles after the trigger, FSM returns to IDLE, lock is cleared.
REQ-039 tx_busy_in is high while in IDLE with valid requesters -> req_ready_out stays 0 until busy falls.
REQ-040 rst_n_in is pulsed low during WAIT_DONE -> all outputs are 0 in the same cycle, and the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and default parameters for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_BUSY_TIMEOUT = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the arbiter; slave is the arbiter side.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) ();

  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid_in;
  logic [NUM_REQ*8-1:0] req_data_in;
  logic [NUM_REQ-1:0]   req_last_in;
  logic [NUM_REQ-1:0]   req_ready_out;
  logic [7:0]           tx_data_out;
  logic                 tx_trigger_out;
  logic                 tx_busy_in;
  logic [IDW-1:0]       grant_id_out;
  logic                 grant_active_out;
  logic                 timeout_err_out;

  modport slave (
    input  req_valid_in, req_data_in, req_last_in, tx_busy_in,
    output req_ready_out, tx_data_out, tx_trigger_out, grant_id_out,
           grant_active_out, timeout_err_out
  );

  modport master (
    output req_valid_in, req_data_in, req_last_in, tx_busy_in,
    input  req_ready_out, tx_data_out, tx_trigger_out, grant_id_out,
           grant_active_out, timeout_err_out
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: the first requester at or above i_ptr, wrapping.
module rr_pick #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);

  int w_best;
  int w_off;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    o_any  = 1'b0;
    o_idx  = '0;
    w_best = N;
    w_off  = 0;
    for (int i = 0; i < N; i++) begin
      if (i_req[i]) begin
        w_off = (i + N - int'(i_ptr)) % N;
        if (w_off < w_best) begin
          w_best = w_off;
          o_idx  = IDW'(i);
          o_any  = 1'b1;
        end
      end
    end
  end

  assign o_gnt = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters, keeping multi-byte
// messages contiguous and recovering from a transmitter that never goes busy.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input logic              clk_in,
  input logic              rst_n_in,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t     r_state;
  logic [IDW-1:0] r_last_grant;
  logic [IDW-1:0] r_lock_id;
  logic           r_lock;
  logic [IDW-1:0] r_grant_id;
  logic [7:0]     r_tx_data;
  logic           r_grant_active;
  logic           r_trigger;
  logic           r_timeout;
  logic [CW-1:0]  r_cnt;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDW-1:0]     w_ptr;
  logic [IDW-1:0]     w_idx;
  logic               w_any;
  logic               w_accept;
  logic               w_last;
  logic [7:0]         w_data;

  // A locked message owner is the only candidate until its last byte goes through.
  assign w_elig = r_lock ? (bus.req_valid_in & (NUM_REQ'(1) << r_lock_id))
                         : bus.req_valid_in;
  assign w_ptr  = (r_last_grant == IDW'(NUM_REQ - 1)) ? '0 : r_last_grant + 1'b1;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .i_req (w_elig),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Ready is gated by reset too, so every output reads zero while rst_n_in is low.
  assign w_accept          = rst_n_in && (r_state == ST_IDLE) && !bus.tx_busy_in && w_any;
  assign bus.req_ready_out = w_accept ? w_gnt : '0;
  assign w_last            = |(bus.req_last_in & w_gnt);

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_data = bus.req_data_in[8*i +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state        <= ST_IDLE;
      r_last_grant   <= IDW'(NUM_REQ - 1);
      r_lock_id      <= '0;
      r_lock         <= 1'b0;
      r_grant_id     <= '0;
      r_tx_data      <= '0;
      r_grant_active <= 1'b0;
      r_trigger      <= 1'b0;
      r_timeout      <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_trigger <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tx_data      <= w_data;
            r_grant_id     <= w_idx;
            r_grant_active <= 1'b1;
            r_trigger      <= 1'b1;
            r_state        <= ST_LAUNCH;
            if (w_last) begin
              r_lock       <= 1'b0;
              r_last_grant <= w_idx;
            end else begin
              r_lock    <= 1'b1;
              r_lock_id <= w_idx;
            end
          end
        end
        ST_LAUNCH: begin
          r_cnt   <= CW'(1);
          r_state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (bus.tx_busy_in) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT_DONE;
          end else if (r_cnt >= CW'(BUSY_TIMEOUT - 1)) begin
            // Counter value k means k cycles have elapsed since the trigger pulse.
            r_timeout      <= 1'b1;
            r_lock         <= 1'b0;
            r_last_grant   <= r_grant_id;
            r_grant_active <= 1'b0;
            r_cnt          <= '0;
            r_state        <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy_in) begin
            r_grant_active <= 1'b0;
            r_state        <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_data_out      = r_tx_data;
  assign bus.tx_trigger_out   = r_trigger;
  assign bus.grant_id_out     = r_grant_id;
  assign bus.grant_active_out = r_grant_active;
  assign bus.timeout_err_out  = r_timeout;

endmodule
